// File: rtl/pixel_tap_mac_pkg.sv
// Shared fixed-point constants and FSM encoding for the tap MAC and the downstream clipper.
package pixel_tap_mac_pkg;

  localparam int FRAC_BITS  = 7;
  localparam int ROUND_BIAS = 64;
  localparam int COEF_ONE   = 128;

  localparam int DEF_PIX_W  = 8;
  localparam int DEF_COEF_W = 9;
  localparam int DEF_ACC_W  = 20;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/pixel_tap_mac_if.sv
// Tap input stream plus result output stream of the pixel tap MAC.
interface pixel_tap_mac_if
  import pixel_tap_mac_pkg::*;
#(
  parameter int PIX_W  = DEF_PIX_W,
  parameter int COEF_W = DEF_COEF_W,
  parameter int ACC_W  = DEF_ACC_W
) ();

  logic              s_valid;
  logic              s_ready;
  logic [PIX_W-1:0]  s_pixel;
  logic [COEF_W-1:0] s_coef;
  logic              s_last;
  logic              m_valid;
  logic              m_ready;
  logic [ACC_W-1:0]  m_data;
  logic              m_err;

  // Driver side: produces taps, consumes results.
  modport master (
    output s_valid, s_pixel, s_coef, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_err
  );

  // MAC side.
  modport slave (
    input  s_valid, s_pixel, s_coef, s_last, m_ready,
    output s_ready, m_valid, m_data, m_err
  );

endinterface

// File: rtl/pixel_tap_mac_mult.sv
// Combinational unsigned-pixel by signed-coefficient multiplier, sign-extended to ACC_W.
module pix_coef_mult #(
  parameter int PIX_W  = 8,
  parameter int COEF_W = 9,
  parameter int ACC_W  = 20
) (
  input  logic [PIX_W-1:0]         pixel,
  input  logic [COEF_W-1:0]        coef,
  output logic signed [ACC_W-1:0]  product
);

  localparam int PROD_W = PIX_W + COEF_W + 1;

  logic signed [PROD_W-1:0] pix_ext;
  logic signed [PROD_W-1:0] coef_ext;
  logic signed [PROD_W-1:0] prod_full;

  // Both operands widened to the full product width so the multiply is exact.
  assign pix_ext   = {{(PROD_W-PIX_W){1'b0}}, pixel};
  assign coef_ext  = {{(PROD_W-COEF_W){coef[COEF_W-1]}}, coef};
  assign prod_full = pix_ext * coef_ext;
  assign product   = ACC_W'(prod_full);

endmodule

// File: rtl/pixel_tap_mac.sv
// Serial multiply-accumulate over TAPS (pixel, coefficient) taps with a saturating sum
// and a single-entry result hold stage.
module pixel_tap_mac
  import pixel_tap_mac_pkg::*;
#(
  parameter int TAPS   = 4,
  parameter int PIX_W  = DEF_PIX_W,
  parameter int COEF_W = DEF_COEF_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic           clk,
  input  logic           rst,
  pixel_tap_mac_if.slave bus
);

  localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [CNT_W-1:0]        LAST_IDX = CNT_W'(TAPS - 1);
  localparam logic signed [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

  state_t state, next_state;

  logic [CNT_W-1:0]        tap_cnt;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] product;
  logic signed [ACC_W-1:0] acc_base;
  logic signed [ACC_W:0]   wide_sum;
  logic signed [ACC_W-1:0] sat_sum;
  logic [ACC_W-1:0]        data_q;
  logic                    err_q;
  logic                    tap_fire;
  logic                    at_max;
  logic                    final_tap;

  pix_coef_mult #(
    .PIX_W  (PIX_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mult (
    .pixel   (bus.s_pixel),
    .coef    (bus.s_coef),
    .product (product)
  );

  assign bus.s_ready = (state == ACCUM);
  assign bus.m_valid = (state == HOLD);
  assign bus.m_data  = data_q;
  assign bus.m_err   = err_q;

  // The first tap of a sample restarts from zero, so a stale acc never leaks forward.
  always_comb begin
    tap_fire  = bus.s_valid && (state == ACCUM);
    at_max    = (tap_cnt == LAST_IDX);
    final_tap = bus.s_last || at_max;
    acc_base  = (tap_cnt == '0) ? '0 : acc;
    wide_sum  = {acc_base[ACC_W-1], acc_base} + {product[ACC_W-1], product};
    sat_sum   = wide_sum[ACC_W-1:0];
    if (wide_sum[ACC_W] != wide_sum[ACC_W-1]) begin
      sat_sum = wide_sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ACCUM:   if (tap_fire && final_tap) next_state = HOLD;
      HOLD:    if (bus.m_ready)           next_state = ACCUM;
      default: next_state = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ACCUM;
      tap_cnt <= '0;
      acc     <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= next_state;
      if (tap_fire) begin
        acc <= sat_sum;
        if (final_tap) begin
          data_q  <= sat_sum;
          err_q   <= (bus.s_last != at_max);
          tap_cnt <= '0;
        end else begin
          tap_cnt <= tap_cnt + 1'b1;
        end
      end
    end
  end

endmodule
